mt9v_capture: RTL and testbench
===============================

# mt9v_capture

Parametrised camera input front end for the MT9V-family sensor path. It registers the parallel pixel bus and the frame and line syncs on `pclk`, normalises sync polarity, and discards any partial frame after reset. It adds pixel-valid, start/end-of-frame and start/end-of-line markers, x/y pixel coordinates, per-line and per-frame geometry checks, and a frame counter. It sits between the sensor pins and the filter pipeline and supersedes the plain input register stage.

## Interface
- `DW`, 8: pixel data width
- `FM_POL`, 1: active level of `fm_in` (1 = active-high, 0 = active-low)
- `LN_POL`, 1: active level of `ln_in`
- `XW`, 10: width of the x coordinate and pixel counter
- `YW`, 9: width of the y coordinate and line counter
- `EXP_W`, 752: expected pixels per line
- `EXP_H`, 480: expected lines per frame

Ports:
- `pclk` in 1: pixel clock, the only clock
- `rst_n` in 1: asynchronous active-low reset
- `data_in` in DW: sensor pixel bus
- `fm_in` in 1: frame valid, polarity set by `FM_POL`
- `ln_in` in 1: line valid, polarity set by `LN_POL`
- `data_out` out DW: registered pixel
- `fm_out` out 1: frame valid, normalised active-high and gated by sync state
- `ln_out` out 1: line valid, normalised active-high and gated
- `px_valid` out 1: `fm_out & ln_out`
- `sof` out 1: start-of-frame pulse
- `eof` out 1: end-of-frame pulse
- `sol` out 1: first pixel of a line
- `eol` out 1: line-end pulse
- `x` out XW: column of the current `data_out` pixel
- `y` out YW: row of the current `data_out` pixel
- `line_err` out 1: pulse, line length not equal to `EXP_W`
- `frame_err` out 1: pulse, line count not equal to `EXP_H`
- `frame_cnt` out 16: completed-frame counter

## Operation
- **Stage 1 (IOB register):**
  - `d1 <= data_in`
  - `f1 <= fm_in ~^ FM_POL`
  - `l1 <= ln_in ~^ LN_POL`
  - No logic is allowed between the pins and this register.
- **Stage 2 (output):** all outputs are registered.
  - Edges are detected as `f1` vs `fm_raw2` and `l1` vs `ln_raw2`, where `fm_raw2` and `ln_raw2` are ungated stage-2 copies.
- **State machine:**
  - `SYNC` (reset state): wait for `f1 = 0`, then go to `IDLE`. While in `SYNC`, `fm_out`, `ln_out`, `px_valid` and all markers are held at 0.
  - `IDLE`: on a rising edge of `f1`, go to `FRAME` and assert `sof`.
  - `FRAME`: on a falling edge of `f1`, assert `eof` and go to `IDLE`.
- **Line markers:**
  - `sol` fires in `FRAME` (including the `sof` cycle) when `f1 & l1` rises.
  - `eol` fires on the first cycle after the last pixel of a line: `l1` falls while in `FRAME`, or `f1` falls while `ln_raw2 = 1`.
- **Coordinates:**
  - `x` is 0 on `sol` and increments on each subsequent `px_valid`. It saturates at `2^XW-1`.
  - `y` is 0 on the first `sol` of a frame and increments on each later `sol`. It saturates at `2^YW-1`.
  - `x` and `y` hold their values when `px_valid = 0`.
- **Line check:** the pixel count of the line is `x+1` of its last pixel, saturating. If it is not equal to `EXP_W`, `line_err` pulses in the same cycle as `eol`.
- **Frame check:**
  - The line count is the number of `sol` events in the frame, saturating at `2^YW-1`.
  - If it is not equal to `EXP_H` at `eof`, `frame_err` pulses with `eof`.
- **Frame counter:** `frame_cnt` increments by 1 on every `eof` and wraps from 0xFFFF to 0.
- **Ignored activity:** `l1` activity while not in `FRAME` is ignored, with no markers and no counts.

## Timing
- **Reset values:** while `rst_n = 0`, all outputs, `d1`, `f1`, `l1`, the counters and the state are 0 or `SYNC`. The reset takes effect immediately (asynchronous). It is released synchronously into `SYNC`.
- **Latency:** pin to `data_out`, `fm_out`, `ln_out` and `px_valid` is 2 `pclk` cycles. `sol`, `sof`, `x` and `y` are aligned with the `data_out` pixel they describe.
- **Pulse width:** `sof`, `eof`, `sol`, `eol`, `line_err` and `frame_err` are exactly 1 cycle wide.
- **Simultaneous events:**
  - `f1` and `l1` rising together: `sof`, `sol` and `px_valid` in one cycle, with `x = 0`, `y = 0`.
  - `f1` falling while the line is active: `eol`, `eof`, and any `line_err` / `frame_err` in the same cycle. That line counts toward the frame.
- **Frame already active at reset release:** stay in `SYNC` until `fm` goes inactive. No output activity for that frame and `frame_cnt` is unchanged.
- **Reset asserted mid-frame:** all state is lost. On release the block resynchronises through `SYNC`.
- **Zero-length frame** (fm pulse with no lines): `sof`, then `eof`. `frame_err` is asserted if `EXP_H != 0`, and `frame_cnt` increments.

## Test plan
- **Nominal frame:** default parameters, one frame of 480 lines × 752 px. Expect `sof` once, 480 `sol` and 480 `eol`, `x` max 751, `y` max 479, no errors, `frame_cnt = 1`. `data_out` equals `data_in` delayed by 2 cycles.
- **Bad geometry:** one line of 750 px, then a frame of 479 lines. Expect `line_err` on that line's `eol` only, and `frame_err` on the `eof` of the 479-line frame.
- **Mid-frame reset release:** release `rst_n` while `fm_in` is active, mid-line. Expect no `px_valid` or markers until the next `fm` rise. `frame_cnt` is 0 until the first full frame ends.
- **Inverted sync polarity:** `FM_POL = 0`, `LN_POL = 0`, with inverted stimulus. Expect results identical to the nominal frame.
- **Coincident edges:** `fm` and `ln` rise on the same cycle, and `fm` falls while `ln` is high. Expect `sof` with `sol`, and `eol` with `eof`, each in a single cycle.
- **Counter wrap:** preload or run 65536 short frames (`EXP_W = 4`, `EXP_H = 2`). Expect `frame_cnt` to wrap from 0xFFFF to 0x0000 with no error pulses.

Source files
------------

// File: rtl/mt9v_capture.sv
// rtl/mt9v_capture.sv - MT9V camera input front end: IOB register, sync normalisation,
// frame/line markers, pixel coordinates, geometry checks and frame counter.
module mt9v_capture #(
  parameter int DW     = 8,
  parameter int FM_POL = 1,
  parameter int LN_POL = 1,
  parameter int XW     = 10,
  parameter int YW     = 9,
  parameter int EXP_W  = 752,
  parameter int EXP_H  = 480
) (
  input  logic          pclk,
  input  logic          rst_n,
  input  logic [DW-1:0] data_in,
  input  logic          fm_in,
  input  logic          ln_in,
  output logic [DW-1:0] data_out,
  output logic          fm_out,
  output logic          ln_out,
  output logic          px_valid,
  output logic          sof,
  output logic          eof,
  output logic          sol,
  output logic          eol,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          line_err,
  output logic          frame_err,
  output logic [15:0]   frame_cnt
);

  typedef enum logic [1:0] {SYNC, IDLE, FRAME} state_e;

  localparam logic          FM_P = 1'(FM_POL);
  localparam logic          LN_P = 1'(LN_POL);
  localparam logic [XW-1:0] XMAX = {XW{1'b1}};
  localparam logic [YW-1:0] YMAX = {YW{1'b1}};

  state_e        state_q, state_d;
  logic [DW-1:0] d1_q, d1_d, data_out_q, data_out_d;
  logic          f1_q, f1_d, l1_q, l1_d, v1_q, v1_d;
  logic          fm_raw2_q, fm_raw2_d, ln_raw2_q, ln_raw2_d;
  logic          fm_out_q, fm_out_d, ln_out_q, ln_out_d, px_valid_q, px_valid_d;
  logic          sof_q, sof_d, eof_q, eof_d, sol_q, sol_d, eol_q, eol_d;
  logic          line_err_q, line_err_d, frame_err_q, frame_err_d;
  logic [XW-1:0] x_q, x_d, line_len;
  logic [YW-1:0] y_q, y_d, lc_q, lc_d, lc_cur;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic          f_rise, f_fall, fl_rise, in_frame;

  always_comb begin
    d1_d        = data_in;
    f1_d        = fm_in ~^ FM_P;
    l1_d        = ln_in ~^ LN_P;
    v1_d        = 1'b1;
    data_out_d  = d1_q;
    fm_raw2_d   = f1_q;
    ln_raw2_d   = l1_q;
    state_d     = state_q;
    sof_d       = 1'b0;
    eof_d       = 1'b0;
    x_d         = x_q;
    y_d         = y_q;
    f_rise      = f1_q & ~fm_raw2_q;
    f_fall      = ~f1_q & fm_raw2_q;
    fl_rise     = f1_q & l1_q & ~(fm_raw2_q & ln_raw2_q);

    case (state_q)
      // v1_q guards against trusting the reset value of f1 on the first cycle
      SYNC:    if (v1_q && !f1_q) state_d = IDLE;
      IDLE:    if (f_rise) begin state_d = FRAME; sof_d = 1'b1; end
      FRAME:   if (f_fall) begin state_d = IDLE;  eof_d = 1'b1; end
      default: state_d = SYNC;
    endcase

    in_frame    = (state_d == FRAME);
    fm_out_d    = f1_q & in_frame;
    ln_out_d    = l1_q & in_frame;
    px_valid_d  = fm_out_d & ln_out_d;
    sol_d       = in_frame & fl_rise;
    eol_d       = (state_q == FRAME) & ln_out_q & (~l1_q | ~f1_q);

    lc_cur = sof_d ? '0 : lc_q;
    lc_d   = lc_cur;
    if (sol_d) begin
      x_d  = '0;
      y_d  = (lc_cur == '0) ? '0 : ((y_q == YMAX) ? y_q : y_q + 1'b1);
      lc_d = (lc_cur == YMAX) ? lc_cur : lc_cur + 1'b1;
    end else if (px_valid_d) begin
      x_d  = (x_q == XMAX) ? x_q : x_q + 1'b1;
    end

    line_len    = (x_q == XMAX) ? x_q : x_q + 1'b1;
    line_err_d  = eol_d & (32'(line_len) != EXP_W);
    frame_err_d = eof_d & (32'(lc_q) != EXP_H);
    frame_cnt_d = frame_cnt_q + 16'(eof_d);
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      d1_q <= '0; f1_q <= 1'b0; l1_q <= 1'b0; v1_q <= 1'b0;
      state_q <= SYNC;
      data_out_q <= '0; fm_raw2_q <= 1'b0; ln_raw2_q <= 1'b0;
      fm_out_q <= 1'b0; ln_out_q <= 1'b0; px_valid_q <= 1'b0;
      sof_q <= 1'b0; eof_q <= 1'b0; sol_q <= 1'b0; eol_q <= 1'b0;
      x_q <= '0; y_q <= '0; lc_q <= '0;
      line_err_q <= 1'b0; frame_err_q <= 1'b0; frame_cnt_q <= '0;
    end else begin
      d1_q <= d1_d; f1_q <= f1_d; l1_q <= l1_d; v1_q <= v1_d;
      state_q <= state_d;
      data_out_q <= data_out_d; fm_raw2_q <= fm_raw2_d; ln_raw2_q <= ln_raw2_d;
      fm_out_q <= fm_out_d; ln_out_q <= ln_out_d; px_valid_q <= px_valid_d;
      sof_q <= sof_d; eof_q <= eof_d; sol_q <= sol_d; eol_q <= eol_d;
      x_q <= x_d; y_q <= y_d; lc_q <= lc_d;
      line_err_q <= line_err_d; frame_err_q <= frame_err_d; frame_cnt_q <= frame_cnt_d;
    end
  end

  assign data_out  = data_out_q;
  assign fm_out    = fm_out_q;
  assign ln_out    = ln_out_q;
  assign px_valid  = px_valid_q;
  assign sof       = sof_q;
  assign eof       = eof_q;
  assign sol       = sol_q;
  assign eol       = eol_q;
  assign x         = x_q;
  assign y         = y_q;
  assign line_err  = line_err_q;
  assign frame_err = frame_err_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_mt9v_capture.sv
// tb/tb_mt9v_capture.sv - directed bench: normal- and inverted-polarity instances
// driven with identical frames, small geometry (4 px x 3 lines, XW=3, YW=2).
module tb_mt9v_capture;

  logic       pclk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_in = '0;
  logic       fm = 1'b0, ln = 1'b0;
  logic       fm_n, ln_n;

  logic [7:0]  dout  [2];
  logic        fmo   [2], lno [2], pxv [2], sof [2], eof [2], sol [2], eol [2];
  logic        lerr  [2], ferr [2];
  logic [2:0]  xo    [2];
  logic [1:0]  yo    [2];
  logic [15:0] fcnt  [2];

  int n_chk = 0, n_err = 0;
  int cnt [2][7];
  int xmax [2], ymax [2], ss [2], ee [2], stray [2];
  logic [7:0] dly1 = '0, dly2 = '0;

  assign fm_n = ~fm;
  assign ln_n = ~ln;

  always #5 pclk = ~pclk;

  mt9v_capture #(.DW(8), .FM_POL(1), .LN_POL(1), .XW(3), .YW(2), .EXP_W(4), .EXP_H(3)) u_dut (
    .pclk(pclk), .rst_n(rst_n), .data_in(data_in), .fm_in(fm), .ln_in(ln),
    .data_out(dout[0]), .fm_out(fmo[0]), .ln_out(lno[0]), .px_valid(pxv[0]),
    .sof(sof[0]), .eof(eof[0]), .sol(sol[0]), .eol(eol[0]), .x(xo[0]), .y(yo[0]),
    .line_err(lerr[0]), .frame_err(ferr[0]), .frame_cnt(fcnt[0]));

  mt9v_capture #(.DW(8), .FM_POL(0), .LN_POL(0), .XW(3), .YW(2), .EXP_W(4), .EXP_H(3)) u_inv (
    .pclk(pclk), .rst_n(rst_n), .data_in(data_in), .fm_in(fm_n), .ln_in(ln_n),
    .data_out(dout[1]), .fm_out(fmo[1]), .ln_out(lno[1]), .px_valid(pxv[1]),
    .sof(sof[1]), .eof(eof[1]), .sol(sol[1]), .eol(eol[1]), .x(xo[1]), .y(yo[1]),
    .line_err(lerr[1]), .frame_err(ferr[1]), .frame_cnt(fcnt[1]));

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", tag, act, exp);
    end
  endtask

  always @(posedge pclk) begin
    dly2 = dly1;
    dly1 = data_in;
  end

  always @(negedge pclk) begin
    for (int i = 0; i < 2; i++) begin
      cnt[i][0] += int'(sof[i]);
      cnt[i][1] += int'(sol[i]);
      cnt[i][2] += int'(eol[i]);
      cnt[i][3] += int'(eof[i]);
      cnt[i][4] += int'(lerr[i]);
      cnt[i][5] += int'(ferr[i]);
      cnt[i][6] += int'(pxv[i]);
      if (pxv[i] && int'(xo[i]) > xmax[i]) xmax[i] = int'(xo[i]);
      if (pxv[i] && int'(yo[i]) > ymax[i]) ymax[i] = int'(yo[i]);
      if (sof[i] && sol[i]) ss[i]++;
      if (eol[i] && eof[i]) ee[i]++;
      if ((lerr[i] && !eol[i]) || (ferr[i] && !eof[i]) || (pxv[i] && !(fmo[i] && lno[i])))
        stray[i]++;
      if (pxv[i]) chk($sformatf("data%0d", i), int'(dout[i]), int'(dly2));
    end
  end

  task automatic clr();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 7; k++) cnt[i][k] = 0;
      xmax[i] = 0; ymax[i] = 0; ss[i] = 0; ee[i] = 0; stray[i] = 0;
    end
  endtask

  task automatic drive(input logic f, input logic l);
    fm = f;
    ln = l;
    data_in = data_in + 8'd1;
    @(posedge pclk);
    #1;
  endtask

  task automatic frame(input int nl, input int bad_i, input int bad_w, input bit coin);
    int w;
    if (!coin) begin drive(1, 0); drive(1, 0); end
    for (int i = 0; i < nl; i++) begin
      w = (i == bad_i) ? bad_w : 4;
      for (int j = 0; j < w; j++) drive(1, 1);
      if (!(coin && i == nl - 1)) begin drive(1, 0); drive(1, 0); end
    end
    for (int i = 0; i < 4; i++) drive(0, 0);
  endtask

  task automatic expect_ev(input string tag, input int e_sof, input int e_sol, input int e_eol,
                           input int e_eof, input int e_le, input int e_fe, input int e_px,
                           input int e_fc);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_sof%0d", tag, i), cnt[i][0], e_sof);
      chk($sformatf("%s_sol%0d", tag, i), cnt[i][1], e_sol);
      chk($sformatf("%s_eol%0d", tag, i), cnt[i][2], e_eol);
      chk($sformatf("%s_eof%0d", tag, i), cnt[i][3], e_eof);
      chk($sformatf("%s_lerr%0d", tag, i), cnt[i][4], e_le);
      chk($sformatf("%s_ferr%0d", tag, i), cnt[i][5], e_fe);
      chk($sformatf("%s_px%0d", tag, i), cnt[i][6], e_px);
      chk($sformatf("%s_fcnt%0d", tag, i), int'(fcnt[i]), e_fc);
      chk($sformatf("%s_stray%0d", tag, i), stray[i], 0);
    end
  endtask

  initial begin
    clr();
    repeat (3) @(posedge pclk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_px%0d", i), int'(pxv[i]), 0);
      chk($sformatf("rst_fm%0d", i), int'(fmo[i]), 0);
      chk($sformatf("rst_dout%0d", i), int'(dout[i]), 0);
      chk($sformatf("rst_fcnt%0d", i), int'(fcnt[i]), 0);
    end
    rst_n = 1'b1;
    repeat (3) drive(0, 0);

    // nominal frame
    clr();
    frame(3, -1, 0, 1'b0);
    expect_ev("nom", 1, 3, 3, 1, 0, 0, 12, 1);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("nom_xmax%0d", i), xmax[i], 3);
      chk($sformatf("nom_ymax%0d", i), ymax[i], 2);
    end

    // short line, then short frame
    clr();
    frame(3, 1, 2, 1'b0);
    frame(2, -1, 0, 1'b0);
    expect_ev("geo", 2, 5, 5, 2, 1, 1, 18, 3);

    // coincident fm/ln edges
    clr();
    frame(3, -1, 0, 1'b1);
    expect_ev("coin", 1, 3, 3, 1, 0, 0, 12, 4);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("coin_sofsol%0d", i), ss[i], 1);
      chk($sformatf("coin_eoleof%0d", i), ee[i], 1);
    end

    // overlong line and extra line: x and line count saturate
    clr();
    frame(4, 3, 9, 1'b0);
    expect_ev("sat", 1, 4, 4, 1, 1, 0, 21, 5);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("sat_xmax%0d", i), xmax[i], 7);
      chk($sformatf("sat_ymax%0d", i), ymax[i], 3);
    end

    // line activity outside a frame, then zero-length frame
    clr();
    repeat (3) drive(0, 1);
    repeat (2) drive(0, 0);
    frame(0, -1, 0, 1'b0);
    expect_ev("zero", 1, 0, 0, 1, 0, 1, 0, 6);

    // asynchronous reset mid-line, release while frame still active
    drive(1, 0); drive(1, 0);
    repeat (3) drive(1, 1);
    for (int i = 0; i < 2; i++) chk($sformatf("pre_rst_px%0d", i), int'(pxv[i]), 1);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("arst_px%0d", i), int'(pxv[i]), 0);
      chk($sformatf("arst_fcnt%0d", i), int'(fcnt[i]), 0);
    end
    repeat (2) drive(1, 1);
    rst_n = 1'b1;
    clr();
    repeat (3) drive(1, 1);
    repeat (2) drive(1, 0);
    repeat (4) drive(1, 1);
    repeat (4) drive(0, 0);
    expect_ev("midrst", 0, 0, 0, 0, 0, 0, 0, 0);
    clr();
    frame(3, -1, 0, 1'b0);
    expect_ev("post", 1, 3, 3, 1, 0, 0, 12, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
